// File: rtl/regfile_op_sequencer.sv
// Single-command sequencer for the 16x16 2R/1W register file: fetch, compute, write back, respond.
// Define REGSEQ_SAT_EN to saturate ADD/ADDI/SUB results instead of wrapping.
module regfile_op_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_dst_i,
    input  logic [ADDR_W-1:0] cmd_src1_i,
    input  logic [ADDR_W-1:0] cmd_src2_i,
    input  logic [DATA_W-1:0] cmd_imm_i,
    output logic              rf_write_en_o,
    output logic [ADDR_W-1:0] rf_in_address_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic [ADDR_W-1:0] rf_out1_address_o,
    output logic [ADDR_W-1:0] rf_out2_address_o,
    input  logic [DATA_W-1:0] rf_out1_i,
    input  logic [DATA_W-1:0] rf_out2_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_ovf_o
);
    typedef enum logic [1:0] {StIdle, StFetch, StWb, StResp} state_e;

    localparam logic [2:0] OpMovi = 3'd0;
    localparam logic [2:0] OpAdd  = 3'd1;
    localparam logic [2:0] OpSub  = 3'd2;
    localparam logic [2:0] OpAnd  = 3'd3;
    localparam logic [2:0] OpOr   = 3'd4;
    localparam logic [2:0] OpXor  = 3'd5;
    localparam logic [2:0] OpRead = 3'd6;
    localparam logic [2:0] OpAddi = 3'd7;

    state_e              state_q, state_d;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   dst_q, raddr1_q, raddr2_q;
    logic [DATA_W-1:0]   imm_q, opa_q, opb_q;
    logic [DATA_W-1:0]   result;
    logic                ovf;
    logic [DATA_W:0]     wide;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            op_q     <= OpMovi;
            dst_q    <= '0;
            raddr1_q <= '0;
            raddr2_q <= '0;
            imm_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && cmd_valid_i) begin
                op_q  <= cmd_op_i;
                dst_q <= cmd_dst_i;
                imm_q <= cmd_imm_i;
                // MOVI has no FETCH, so read addresses keep their previous value.
                if (cmd_op_i != OpMovi) begin
                    raddr1_q <= cmd_src1_i;
                    raddr2_q <= cmd_src2_i;
                end
            end
            if (state_q == StFetch) begin
                opa_q <= rf_out1_i;
                opb_q <= rf_out2_i;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready_o   = 1'b0;
        rf_write_en_o = 1'b0;
        rsp_valid_o   = 1'b0;
        case (state_q)
            StIdle: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_d = (cmd_op_i == OpMovi) ? StWb : StFetch;
            end
            StFetch: state_d = (op_q == OpRead) ? StResp : StWb;
            StWb: begin
                rf_write_en_o = 1'b1;
                state_d       = StResp;
            end
            StResp: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Result depends only on registered state, so it is stable through WB and RESP.
    always_comb begin
        wide   = '0;
        result = '0;
        ovf    = 1'b0;
        case (op_q)
            OpMovi: result = imm_q;
            OpAdd: begin
                wide   = {1'b0, opa_q} + {1'b0, opb_q};
                result = wide[DATA_W-1:0];
                ovf    = wide[DATA_W];
            end
            OpSub: begin
                wide   = {1'b0, opa_q} - {1'b0, opb_q};
                result = wide[DATA_W-1:0];
                ovf    = wide[DATA_W];
            end
            OpAnd:  result = opa_q & opb_q;
            OpOr:   result = opa_q | opb_q;
            OpXor:  result = opa_q ^ opb_q;
            OpRead: result = opa_q;
            OpAddi: begin
                wide   = {1'b0, opa_q} + {1'b0, imm_q};
                result = wide[DATA_W-1:0];
                ovf    = wide[DATA_W];
            end
            default: result = opa_q;
        endcase
`ifdef REGSEQ_SAT_EN
        if (ovf) result = (op_q == OpSub) ? '0 : '1;
`else
`endif
    end

    assign rf_in_address_o   = dst_q;
    assign rf_wdata_o        = result;
    assign rf_out1_address_o = raddr1_q;
    assign rf_out2_address_o = raddr2_q;
    assign rsp_data_o        = result;
    assign rsp_ovf_o         = ovf;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: bench-owned register file, transaction-level model, directed tests.
module tb_regfile_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [3:0]  cmd_dst = '0, cmd_src1 = '0, cmd_src2 = '0;
    logic [15:0] cmd_imm = '0;
    logic        rf_we;
    logic [3:0]  rf_waddr, rf_raddr1, rf_raddr2;
    logic [15:0] rf_wdata, rf_out1, rf_out2;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        rsp_ovf;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] rf_mem [16];
    logic [15:0] ref_mem [16];

    // Model state: one outstanding command, cycle index k counted from the accept edge.
    logic        m_busy = 1'b0;
    int          m_k = 0;
    int          m_wb_k = 0;
    int          m_rsp_k = 0;
    logic        m_has_wb = 1'b0, m_has_fetch = 1'b0;
    logic [3:0]  m_dst = '0, m_s1 = '0, m_s2 = '0;
    logic [16:0] m_exp = '0;

    always #5 clk = ~clk;

    regfile_op_sequencer #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_dst_i(cmd_dst), .cmd_src1_i(cmd_src1), .cmd_src2_i(cmd_src2), .cmd_imm_i(cmd_imm),
        .rf_write_en_o(rf_we), .rf_in_address_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .rf_out1_address_o(rf_raddr1), .rf_out2_address_o(rf_raddr2),
        .rf_out1_i(rf_out1), .rf_out2_i(rf_out2),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_ovf_o(rsp_ovf)
    );

    assign rf_out1 = rf_mem[rf_raddr1];
    assign rf_out2 = rf_mem[rf_raddr2];

    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end

    function automatic logic [16:0] model_op(int op, int a, int b, int imm);
        int r;
        logic o;
        case (op)
            0: r = imm;
            1: r = a + b;
            2: r = a - b;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = a;
            default: r = a + imm;
        endcase
        o = ((op == 1 || op == 7) && r > 65535) || (op == 2 && r < 0);
`ifdef REGSEQ_SAT_EN
        if (o) r = (op == 2) ? 0 : 65535;
`endif
        return {o, 16'(r)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_has_wb && m_k == m_wb_k) ref_mem[m_dst] <= m_exp[15:0];
            if (m_k >= m_rsp_k && rsp_ready) m_busy <= 1'b0;
            else m_k <= m_k + 1;
        end else if (cmd_valid) begin
            m_exp       <= model_op(int'(cmd_op), int'(ref_mem[cmd_src1]),
                                    int'(ref_mem[cmd_src2]), int'(cmd_imm));
            m_busy      <= 1'b1;
            m_k         <= 1;
            m_has_wb    <= (cmd_op != 3'd6);
            m_has_fetch <= (cmd_op != 3'd0);
            m_wb_k      <= (cmd_op == 3'd0) ? 1 : 2;
            m_rsp_k     <= (cmd_op == 3'd0 || cmd_op == 3'd6) ? 2 : 3;
            m_dst       <= cmd_dst;
            m_s1        <= cmd_src1;
            m_s2        <= cmd_src2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
        chk("write_en", 32'(rf_we), 32'(m_busy && m_has_wb && m_k == m_wb_k));
        if (m_busy && m_has_wb && m_k == m_wb_k) begin
            chk("wb_addr", 32'(rf_waddr), 32'(m_dst));
            chk("wb_data", 32'(rf_wdata), 32'(m_exp[15:0]));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_k >= m_rsp_k));
        if (m_busy && m_k >= m_rsp_k) begin
            chk("rsp_data", 32'(rsp_data), 32'(m_exp[15:0]));
            chk("rsp_ovf", 32'(rsp_ovf), 32'(m_exp[16]));
        end
        if (m_busy && m_has_fetch && m_k == 1) begin
            chk("fetch_addr1", 32'(rf_raddr1), 32'(m_s1));
            chk("fetch_addr2", 32'(rf_raddr2), 32'(m_s2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        if (!cmd_ready) chk("idle_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // Returns at accept edge + 1 time unit, with cmd fields scrambled.
    task automatic send(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [15:0] imm);
        wait_idle();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src1  = s1;
        cmd_src2  = s2;
        cmd_imm   = imm;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_dst   = 4'($urandom);
        cmd_src1  = 4'($urandom);
        cmd_src2  = 4'($urandom);
        cmd_imm   = 16'($urandom);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ovf", 32'(rsp_ovf), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_addrs", {20'd0, rf_waddr, rf_raddr1, rf_raddr2}, 32'd0);
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  dst, s1, s2;
        logic [15:0] imm;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            rf_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        vecs[0] = '{op: 3'd3, dst: 4'd8,  s1: 4'd6, s2: 4'd1, imm: 16'h0};
        vecs[1] = '{op: 3'd4, dst: 4'd9,  s1: 4'd6, s2: 4'd2, imm: 16'h0};
        vecs[2] = '{op: 3'd5, dst: 4'd10, s1: 4'd1, s2: 4'd6, imm: 16'h0};
        vecs[3] = '{op: 3'd7, dst: 4'd6,  s1: 4'd6, s2: 4'd0, imm: 16'd5};
        vecs[4] = '{op: 3'd7, dst: 4'd11, s1: 4'd1, s2: 4'd0, imm: 16'h8000};
        vecs[5] = '{op: 3'd2, dst: 4'd12, s1: 4'd6, s2: 4'd2, imm: 16'h0};
        vecs[6] = '{op: 3'd1, dst: 4'd13, s1: 4'd9, s2: 4'd10, imm: 16'h0};
        vecs[7] = '{op: 3'd6, dst: 4'd0,  s1: 4'd13, s2: 4'd0, imm: 16'h0};

        #12;
        chk_reset_outputs();
        step();
        rst_n = 1'b1;
        step();

        // MOVI r6 = 25: write in E+1, response in E+2.
        send(3'd0, 4'd6, 4'd0, 4'd0, 16'd25);
        chk("movi_we", 32'(rf_we), 32'd1);
        chk("movi_waddr", 32'(rf_waddr), 32'd6);
        chk("movi_wdata", 32'(rf_wdata), 32'd25);
        step();
        chk("movi_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("movi_rsp_data", 32'(rsp_data), 32'd25);
        chk("movi_rsp_ovf", 32'(rsp_ovf), 32'd0);

        // ADD r0 = r6 + r6
        send(3'd1, 4'd0, 4'd6, 4'd6, 16'd0);
        chk("add_fetch_a1", 32'(rf_raddr1), 32'd6);
        chk("add_fetch_a2", 32'(rf_raddr2), 32'd6);
        step();
        chk("add_waddr", 32'(rf_waddr), 32'd0);
        chk("add_wdata", 32'(rf_wdata), 32'd50);
        step();
        chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("add_rsp_data", 32'(rsp_data), 32'd50);

        // Carry and borrow boundaries
        send(3'd0, 4'd1, 4'd0, 4'd0, 16'hFFFF);
        send(3'd0, 4'd2, 4'd0, 4'd0, 16'h0002);
        send(3'd1, 4'd3, 4'd1, 4'd2, 16'h0);
        step();
        step();
`ifdef REGSEQ_SAT_EN
        chk("add_ovf_data", 32'(rsp_data), 32'hFFFF);
`else
        chk("add_ovf_data", 32'(rsp_data), 32'h0001);
`endif
        chk("add_ovf_flag", 32'(rsp_ovf), 32'd1);
        send(3'd2, 4'd4, 4'd2, 4'd1, 16'h0);
        step();
        step();
`ifdef REGSEQ_SAT_EN
        chk("sub_borrow_data", 32'(rsp_data), 32'h0000);
`else
        chk("sub_borrow_data", 32'(rsp_data), 32'h0003);
`endif
        chk("sub_borrow_flag", 32'(rsp_ovf), 32'd1);

        // READ r6 with response back-pressure
        wait_idle();
        rsp_ready = 1'b0;
        send(3'd6, 4'd0, 4'd6, 4'd0, 16'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("read_hold_valid", 32'(rsp_valid), 32'd1);
            chk("read_hold_data", 32'(rsp_data), 32'd25);
            chk("read_hold_ready", 32'(cmd_ready), 32'd0);
            chk("read_hold_we", 32'(rf_we), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("read_done_ready", 32'(cmd_ready), 32'd1);
        chk("read_done_valid", 32'(rsp_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].op, vecs[i].dst, vecs[i].s1, vecs[i].s2, vecs[i].imm);
        end
        wait_idle();
        chk("addi_same_reg", 32'(rf_mem[6]), 32'd30);

        // Asynchronous reset while a response is pending
        rsp_ready = 1'b0;
        send(3'd1, 4'd5, 4'd6, 4'd1, 16'h0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();

        // Asynchronous reset during WB of a SUB: no write to r7
        send(3'd2, 4'd7, 4'd6, 4'd2, 16'h0);
        step();
        chk("sub_wb_we", 32'(rf_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("sub_rst_we", 32'(rf_we), 32'd0);
        chk("sub_rst_ready", 32'(cmd_ready), 32'd1);
        chk("sub_rst_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("sub_no_write", 32'(rf_mem[7]), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        send(3'd6, 4'd0, 4'd7, 4'd0, 16'h0);
        send(3'd7, 4'd14, 4'd7, 4'd0, 16'h1234);
        wait_idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
